floor_request_input: RTL and testbench

- Input-side counterpart of the elevator display path: turns raw floor push-buttons into the latched `floor_btn` request vector that the display and controller consume.
- Per button: synchronise, debounce on a slow sample tick, detect the press edge, then latch a request until the car arrives at that floor.
- Flags each newly registered request with a one-cycle pulse and the floor index.

---
 rtl/floor_request_input.sv | 125 ++++++++++++
 tb/tb_floor_request_input.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/floor_request_input.sv
`default_nettype none
// ============================================================================
// floor_request_input : synchronise, debounce and latch floor push-buttons
//                       into pending requests cleared on car arrival.
// Revision 1.0
// ============================================================================
module floor_request_input #(
    parameter int N_FLOOR        = 8,
    parameter int SAMPLE_DIV     = 100_000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N_FLOOR-1:0] BTN,
    input  logic [3:0]         floor,
    input  logic               arrive,
    output logic [N_FLOOR-1:0] floor_btn,
    output logic               new_req,
    output logic [3:0]         req_idx,
    output logic               any_req
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [DIV_W-1:0]   presc;
    logic               tick;
    logic [N_FLOOR-1:0] sync_meta;
    logic [N_FLOOR-1:0] sync;
    logic [N_FLOOR-1:0] stable;
    logic [N_FLOOR-1:0] stable_d;
    logic [N_FLOOR-1:0] press;
    logic [N_FLOOR-1:0] clr;
    logic [N_FLOOR-1:0] newset;
    logic [3:0]         low_idx;

    assign tick = (presc == DIV_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= BTN;
            sync      <= sync_meta;
        end
    end

    // Any tick on which the synchronised input agrees with the stable state restarts the count.
    for (genvar i = 0; i < N_FLOOR; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt;
        logic             stable_bit;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt        <= '0;
                stable_bit <= 1'b0;
            end else if (tick) begin
                if (sync[i] == stable_bit) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable_bit <= sync[i];
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign stable[i] = stable_bit;
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_FLOOR; i++) begin
            clr[i] = arrive && (floor == 4'(i));
        end
    end

    assign newset = press & ~floor_btn & ~clr;

    always_comb begin
        low_idx = '0;
        for (int i = N_FLOOR - 1; i >= 0; i--) begin
            if (newset[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Press edge is registered, so a request lands two cycles after the debounced flip.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stable_d  <= '0;
            press     <= '0;
            floor_btn <= '0;
            new_req   <= 1'b0;
            req_idx   <= '0;
        end else begin
            stable_d  <= stable;
            press     <= stable & ~stable_d;
            floor_btn <= ~clr & (floor_btn | press);
            new_req   <= |newset;
            if (|newset) begin
                req_idx <= low_idx;
            end
        end
    end

    assign any_req = |floor_btn;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_input.sv
`default_nettype none
// ============================================================================
// tb_floor_request_input : scoreboard bench for floor_request_input
// Revision 1.0
// ============================================================================
module tb_floor_request_input;

    localparam int N_FLOOR        = 8;
    localparam int SAMPLE_DIV     = 4;
    localparam int DEBOUNCE_TICKS = 3;

    logic         CLK    = 1'b0;
    logic         RST_N  = 1'b0;
    logic [7:0]   BTN    = '0;
    logic [3:0]   floor  = '0;
    logic         arrive = 1'b0;
    logic [7:0]   floor_btn;
    logic         new_req;
    logic [3:0]   req_idx;
    logic         any_req;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] btn;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   lat;
    int   t_arr;

    floor_request_input #(
        .N_FLOOR        (N_FLOOR),
        .SAMPLE_DIV     (SAMPLE_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BTN       (BTN),
        .floor     (floor),
        .arrive    (arrive),
        .floor_btn (floor_btn),
        .new_req   (new_req),
        .req_idx   (req_idx),
        .any_req   (any_req)
    );

    always #5 CLK = ~CLK;

    // Cycles since reset release; a debounce sample happens on edges where this is a multiple of 4.
    always @(posedge CLK) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_bit(input int b, input int max, output int l);
        l = 0;
        while (l < max) begin
            step(1);
            l++;
            if (floor_btn[b]) break;
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (new_req === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_new_req", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("req_idx", 32'(req_idx), 32'(e.idx));
                check("floor_btn_at_new_req", 32'(floor_btn), 32'(e.btn));
            end
        end
    end

    initial begin
        RST_N = 1'b0;
        BTN   = 8'hFF;
        step(5);
        check("rst_floor_btn", 32'(floor_btn), 32'h00);
        check("rst_new_req", 32'(new_req), 32'd0);
        check("rst_any_req", 32'(any_req), 32'd0);
        check("rst_req_idx", 32'(req_idx), 32'd0);
        RST_N = 1'b1;
        step(1);
        BTN = 8'h00;
        step(30);
        check("no_latch_after_reset", 32'(floor_btn), 32'h00);

        // Clean press on floor 3
        sb_q.push_back(exp_t'{4'd3, 8'h08});
        BTN[3] = 1'b1;
        wait_bit(3, 40, lat);
        check("press3_latency_window", 32'(lat >= 13 && lat <= 17), 32'd1);
        check("press3_floor_btn", 32'(floor_btn), 32'h08);
        check("press3_any_req", 32'(any_req), 32'd1);
        step(30 - lat);
        check("press3_single_pulse", 32'(sb_q.size()), 32'd0);
        BTN[3] = 1'b0;
        step(25);

        // Bounce on floor 5, phased so a sample falls inside the low gap
        for (int k = 0; k < 4 && (cyc % 4) != 3; k++) step(1);
        BTN[5] = 1'b1; step(6);
        BTN[5] = 1'b0; step(2);
        BTN[5] = 1'b1; step(6);
        BTN[5] = 1'b0; step(30);
        check("bounce_floor_btn", 32'(floor_btn), 32'h08);

        // Simultaneous presses on floors 1 and 6
        sb_q.push_back(exp_t'{4'd1, 8'h4A});
        BTN[1] = 1'b1;
        BTN[6] = 1'b1;
        wait_bit(1, 40, lat);
        check("multi_floor_btn", 32'(floor_btn), 32'h4A);
        step(10);
        check("multi_single_pulse", 32'(sb_q.size()), 32'd0);
        BTN[1] = 1'b0;
        BTN[6] = 1'b0;
        step(25);

        // Servicing
        floor = 4'd3; arrive = 1'b1; step(1); arrive = 1'b0;
        check("arrive3", 32'(floor_btn), 32'h42);
        floor = 4'd9; arrive = 1'b1; step(1); arrive = 1'b0;
        check("arrive9_no_effect", 32'(floor_btn), 32'h42);
        floor = 4'd1; arrive = 1'b1; step(1); arrive = 1'b0;
        check("arrive1", 32'(floor_btn), 32'h40);
        floor = 4'd6; arrive = 1'b1; step(1); arrive = 1'b0;
        check("arrive6", 32'(floor_btn), 32'h00);
        check("arrive6_any_req", 32'(any_req), 32'd0);

        // Collision: arrival at floor 2 in the cycle its press would latch
        BTN[2] = 1'b1;
        t_arr = cyc + 3;
        while ((t_arr % 4) != 0) t_arr++;
        t_arr = t_arr + 2 * SAMPLE_DIV + 1;
        for (int k = 0; k < 40 && cyc < t_arr; k++) step(1);
        floor = 4'd2; arrive = 1'b1; step(1); arrive = 1'b0;
        check("collision_bit2_clear", 32'(floor_btn), 32'h00);
        step(20);
        check("collision_hold_no_req", 32'(floor_btn), 32'h00);
        BTN[2] = 1'b0;
        step(25);

        // Reset part-way through a floor-4 debounce
        BTN[4] = 1'b1;
        step(9);
        RST_N = 1'b0;
        step(2);
        check("midreset_floor_btn", 32'(floor_btn), 32'h00);
        sb_q.push_back(exp_t'{4'd4, 8'h10});
        RST_N = 1'b1;
        wait_bit(4, 40, lat);
        check("post_reset_full_latency", 32'(lat), 32'd14);
        step(5);
        BTN = 8'h00;
        step(25);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
